// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection and a saturating
//   count of the bubbles inserted for load-use hazards.
//
//   Parameters
//     XLEN            width of register operands, immediate and PC
//
//   Inputs
//     clk, rst        rising-edge clock, asynchronous active-high reset
//     IF_ID_RS1/RS2/Rd, IF_ID_Valid
//                     register indices and valid flag of the instruction in decode
//     id_rs1_data, id_rs2_data, id_imm, id_pc
//                     decoded operands, immediate and PC
//     id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_Branch,
//     id_ALUSrc, id_ALUOp
//                     decoded control signals
//     EX_Flush        taken branch/jump resolved in EX, squash decode
//     Hold            global freeze (memory busy)
//
//   Outputs
//     ID_EX_*         registered copy of the decode slot (bubble = controls,
//                     Valid and Rd all zero)
//     PCWrite, IF_ID_Write
//                     combinational enables for PC and IF/ID (always equal)
//     StallCount      saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic [4:0]      IF_ID_RS1,
  input  logic [4:0]      IF_ID_RS2,
  input  logic [4:0]      IF_ID_Rd,
  input  logic            IF_ID_Valid,

  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,

  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_MemtoReg,
  input  logic            id_Branch,
  input  logic            id_ALUSrc,
  input  logic [1:0]      id_ALUOp,

  input  logic            EX_Flush,
  input  logic            Hold,

  output logic [4:0]      ID_EX_RS1,
  output logic [4:0]      ID_EX_RS2,
  output logic [4:0]      ID_EX_Rd,
  output logic [XLEN-1:0] ID_EX_RS1Data,
  output logic [XLEN-1:0] ID_EX_RS2Data,
  output logic [XLEN-1:0] ID_EX_Imm,
  output logic [XLEN-1:0] ID_EX_PC,

  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemtoReg,
  output logic            ID_EX_Branch,
  output logic            ID_EX_ALUSrc,
  output logic [1:0]      ID_EX_ALUOp,
  output logic            ID_EX_Valid,

  output logic            PCWrite,
  output logic            IF_ID_Write,

  output logic [15:0]     StallCount
);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic load_use;     // decode reads the register a load in EX is about to write
  logic bubble;       // next edge (when not held) inserts a bubble
  logic take_ctrl;    // next edge (when not held) passes decode controls through
  logic count_stall;  // next edge (when not held) records a load-use bubble

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = IF_ID_Valid && ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                    ((ID_EX_Rd == IF_ID_RS1) || (ID_EX_Rd == IF_ID_RS2));

  // A flush outranks a load-use: the dependent instruction is squashed anyway,
  // so the front end must advance to the branch target instead of stalling.
  assign bubble      = EX_Flush || load_use;
  assign take_ctrl   = !bubble && IF_ID_Valid;
  assign count_stall = load_use && !EX_Flush && (StallCount != STALL_MAX);

  assign PCWrite     = !rst && !Hold && (EX_Flush || !load_use);
  assign IF_ID_Write = PCWrite;

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and is
  // tested first; every state element gets a value in the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EX_RS1      <= '0;
      ID_EX_RS2      <= '0;
      ID_EX_Rd       <= '0;
      ID_EX_RS1Data  <= '0;
      ID_EX_RS2Data  <= '0;
      ID_EX_Imm      <= '0;
      ID_EX_PC       <= '0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemtoReg <= 1'b0;
      ID_EX_Branch   <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_ALUOp    <= 2'b00;
      ID_EX_Valid    <= 1'b0;
      StallCount     <= '0;
    end else if (!Hold) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; leaving a register unassigned under Hold is a
      // plain flop enable, not a latch, because this block is edge-triggered.
      // Index and data fields are don't-care in a bubble, so they always load.
      ID_EX_RS1      <= IF_ID_RS1;
      ID_EX_RS2      <= IF_ID_RS2;
      ID_EX_RS1Data  <= id_rs1_data;
      ID_EX_RS2Data  <= id_rs2_data;
      ID_EX_Imm      <= id_imm;
      ID_EX_PC       <= id_pc;
      ID_EX_Rd       <= bubble ? 5'd0 : IF_ID_Rd;
      ID_EX_RegWrite <= take_ctrl && id_RegWrite;
      ID_EX_MemRead  <= take_ctrl && id_MemRead;
      ID_EX_MemWrite <= take_ctrl && id_MemWrite;
      ID_EX_MemtoReg <= take_ctrl && id_MemtoReg;
      ID_EX_Branch   <= take_ctrl && id_Branch;
      ID_EX_ALUSrc   <= take_ctrl && id_ALUSrc;
      ID_EX_ALUOp    <= take_ctrl ? id_ALUOp : 2'b00;
      ID_EX_Valid    <= take_ctrl;
      if (count_stall) begin
        StallCount <= StallCount + 16'd1;
      end
    end
  end

endmodule
